// File: rtl/race_timer_pkg.sv
// Shared types and defaults for the race timer sequencing controller.
package race_timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_PAUSED  = 3'd3,
      ST_PENALTY = 3'd4,
      ST_DONE    = 3'd5
   } timer_state_t;

   localparam int TICK_DIV_DEFAULT    = 50_000_000;
   localparam int PENALTY_SEC_DEFAULT = 3;

endpackage

// File: rtl/race_timer_ctrl_tick_prescaler.sv
// Divides the system clock down to the one-second counter tick.
// The tick is registered: it appears the cycle after the prescaler wraps.
module tick_prescaler
   import race_timer_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   input  logic inhibit,
   output logic tick
);

   localparam int               DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] LAST  = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] presc;

   // Holding (not clearing) while !run keeps a paused partial second intact.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (run) begin
            if (presc == LAST) begin
               presc <= '0;
               tick  <= !inhibit;
            end else begin
               presc <= presc + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/race_timer_ctrl.sv
// Start/pause/crash-penalty/finish sequencer for the six-digit race time counter.
// All outputs are registered from the next-state decode.
module race_timer_ctrl
   import race_timer_pkg::*;
#(
   parameter int TICK_DIV    = TICK_DIV_DEFAULT,
   parameter int PENALTY_SEC = PENALTY_SEC_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       crash,
   input  logic       game_over,
   input  logic       cnt_tc,
   output logic       cnt_loadN,
   output logic       cnt_enable1,
   output logic       cnt_enable2,
   output logic       penalty_active,
   output logic       running,
   output logic       done,
   output logic [2:0] state_o
);

   localparam logic [3:0] PEN_LOAD = 4'(PENALTY_SEC);

   timer_state_t state, state_n;
   logic [3:0]   pcnt, pcnt_n;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk     (clk),
      .reset   (reset),
      .clear   (!cnt_loadN),
      .run     (cnt_enable1),
      .inhibit (cnt_tc),
      .tick    (cnt_enable2)
   );

   always_comb begin
      state_n = state;
      pcnt_n  = pcnt;
      case (state)
         ST_IDLE:
            if (start) state_n = ST_LOAD;
         ST_LOAD: begin
            pcnt_n  = '0;
            state_n = game_over ? ST_DONE : ST_RUN;
         end
         ST_RUN:
            if (game_over || cnt_tc) state_n = ST_DONE;
            else if (pause)          state_n = ST_PAUSED;
            else if (crash) begin
               state_n = ST_PENALTY;
               pcnt_n  = PEN_LOAD;
            end
         ST_PAUSED:
            if (game_over)  state_n = ST_DONE;
            else if (start) state_n = ST_LOAD;
            else if (pause) state_n = ST_RUN;
         ST_PENALTY:
            // A crash coinciding with a tick reloads; the tick still reaches the counter.
            if (game_over || cnt_tc) begin
               state_n = ST_DONE;
               pcnt_n  = '0;
            end else if (crash) begin
               pcnt_n  = PEN_LOAD;
            end else if (cnt_enable2) begin
               if (pcnt <= 4'd1) begin
                  pcnt_n  = '0;
                  state_n = ST_RUN;
               end else begin
                  pcnt_n  = pcnt - 4'd1;
               end
            end
         ST_DONE:
            if (start) state_n = ST_LOAD;
         default: begin
            state_n = ST_IDLE;
            pcnt_n  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         pcnt           <= '0;
         cnt_loadN      <= 1'b1;
         cnt_enable1    <= 1'b0;
         penalty_active <= 1'b0;
         running        <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_n;
         pcnt           <= pcnt_n;
         cnt_loadN      <= (state_n != ST_LOAD);
         cnt_enable1    <= (state_n == ST_RUN) || (state_n == ST_PENALTY);
         penalty_active <= (state_n == ST_PENALTY);
         running        <= (state_n == ST_RUN) || (state_n == ST_PENALTY);
         done           <= (state_n == ST_DONE);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_race_timer_ctrl.sv
// Directed bench for race_timer_ctrl with TICK_DIV=4, PENALTY_SEC=3.
module tb_race_timer_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1, start = 1'b0, pause = 1'b0, crash = 1'b0;
   logic       game_over = 1'b0, cnt_tc = 1'b0;
   logic       cnt_loadN, cnt_enable1, cnt_enable2, penalty_active, running, done;
   logic [2:0] state_o;
   logic [8:0] obs;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   race_timer_ctrl #(.TICK_DIV(4), .PENALTY_SEC(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .pause          (pause),
      .crash          (crash),
      .game_over      (game_over),
      .cnt_tc         (cnt_tc),
      .cnt_loadN      (cnt_loadN),
      .cnt_enable1    (cnt_enable1),
      .cnt_enable2    (cnt_enable2),
      .penalty_active (penalty_active),
      .running        (running),
      .done           (done),
      .state_o        (state_o)
   );

   assign obs = {cnt_loadN, cnt_enable1, cnt_enable2, penalty_active, running, done, state_o};

   // Expected {loadN,en1,en2,pen,run,done,state} for a given state code and tick.
   function automatic logic [8:0] ex(input int st, input logic e2);
      logic [8:0] v;
      case (st)
         0:       v = {1'b1, 1'b0, e2, 1'b0, 1'b0, 1'b0, 3'd0};
         1:       v = {1'b0, 1'b0, e2, 1'b0, 1'b0, 1'b0, 3'd1};
         2:       v = {1'b1, 1'b1, e2, 1'b0, 1'b1, 1'b0, 3'd2};
         3:       v = {1'b1, 1'b0, e2, 1'b0, 1'b0, 1'b0, 3'd3};
         4:       v = {1'b1, 1'b1, e2, 1'b1, 1'b1, 1'b0, 3'd4};
         default: v = {1'b1, 1'b0, e2, 1'b0, 1'b0, 1'b1, 3'd5};
      endcase
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(); cyc();
      total++; if (obs !== ex(0, 1'b0)) begin bad++; $display("FAIL reset got=%b exp=%b", obs, ex(0, 1'b0)); end
      reset = 1'b0;
      crash = 1'b1; pause = 1'b1; game_over = 1'b1;
      cyc();
      crash = 1'b0; pause = 1'b0; game_over = 1'b0;
      total++; if (obs !== ex(0, 1'b0)) begin bad++; $display("FAIL idle_ignore got=%b exp=%b", obs, ex(0, 1'b0)); end
   endtask

   task automatic test_start_run();
      start = 1'b1; cyc(); start = 1'b0;
      total++; if (obs !== ex(1, 1'b0)) begin bad++; $display("FAIL load got=%b exp=%b", obs, ex(1, 1'b0)); end
      cyc();
      total++; if (obs !== ex(2, 1'b0)) begin bad++; $display("FAIL run_entry got=%b exp=%b", obs, ex(2, 1'b0)); end
      for (int i = 1; i <= 12; i++) begin
         cyc();
         total++; if (obs !== ex(2, (i % 4) == 0)) begin bad++; $display("FAIL run_tick[%0d] got=%b exp=%b", i, obs, ex(2, (i % 4) == 0)); end
      end
   endtask

   // Entered on a tick cycle; pauses two cycles later, resumes after a hold.
   task automatic test_pause();
      cyc(); cyc();
      pause = 1'b1; cyc(); pause = 1'b0;
      total++; if (obs !== ex(3, 1'b0)) begin bad++; $display("FAIL paused got=%b exp=%b", obs, ex(3, 1'b0)); end
      crash = 1'b1; cyc(); crash = 1'b0;
      total++; if (obs !== ex(3, 1'b0)) begin bad++; $display("FAIL paused_crash got=%b exp=%b", obs, ex(3, 1'b0)); end
      for (int i = 0; i < 5; i++) begin
         cyc();
         total++; if (obs !== ex(3, 1'b0)) begin bad++; $display("FAIL paused_hold[%0d] got=%b exp=%b", i, obs, ex(3, 1'b0)); end
      end
      pause = 1'b1; cyc(); pause = 1'b0;
      total++; if (obs !== ex(2, 1'b0)) begin bad++; $display("FAIL resume got=%b exp=%b", obs, ex(2, 1'b0)); end
      cyc();
      total++; if (obs !== ex(2, 1'b1)) begin bad++; $display("FAIL resume_tick got=%b exp=%b", obs, ex(2, 1'b1)); end
   endtask

   // Entered on a tick cycle T.
   task automatic test_penalty();
      crash = 1'b1; cyc(); crash = 1'b0;
      total++; if (obs !== ex(4, 1'b0)) begin bad++; $display("FAIL pen_entry got=%b exp=%b", obs, ex(4, 1'b0)); end
      for (int c = 2; c <= 12; c++) begin
         cyc();
         total++; if (obs !== ex(4, (c % 4) == 0)) begin bad++; $display("FAIL pen[%0d] got=%b exp=%b", c, obs, ex(4, (c % 4) == 0)); end
      end
      cyc();
      total++; if (obs !== ex(2, 1'b0)) begin bad++; $display("FAIL pen_exit got=%b exp=%b", obs, ex(2, 1'b0)); end
      // Now at N; ticks at N+3, N+7, ...
      crash = 1'b1; cyc(); crash = 1'b0;
      total++; if (obs !== ex(4, 1'b0)) begin bad++; $display("FAIL pen2_entry got=%b exp=%b", obs, ex(4, 1'b0)); end
      cyc();
      cyc();
      total++; if (obs !== ex(4, 1'b1)) begin bad++; $display("FAIL pen2_tick1 got=%b exp=%b", obs, ex(4, 1'b1)); end
      cyc();
      crash = 1'b1; cyc(); crash = 1'b0;
      total++; if (obs !== ex(4, 1'b0)) begin bad++; $display("FAIL pen2_recrash got=%b exp=%b", obs, ex(4, 1'b0)); end
      pause = 1'b1; cyc(); pause = 1'b0;
      total++; if (obs !== ex(4, 1'b0)) begin bad++; $display("FAIL pen2_pause got=%b exp=%b", obs, ex(4, 1'b0)); end
      for (int c = 7; c <= 15; c++) begin
         cyc();
         total++; if (obs !== ex(4, ((c - 3) % 4) == 0)) begin bad++; $display("FAIL pen2[%0d] got=%b exp=%b", c, obs, ex(4, ((c - 3) % 4) == 0)); end
      end
      cyc();
      total++; if (obs !== ex(2, 1'b0)) begin bad++; $display("FAIL pen2_exit got=%b exp=%b", obs, ex(2, 1'b0)); end
   endtask

   // Entered in RUN with the next tick 3 cycles away.
   task automatic test_tc();
      cyc(); cyc();
      total++; if (obs !== ex(2, 1'b0)) begin bad++; $display("FAIL tc_pre got=%b exp=%b", obs, ex(2, 1'b0)); end
      cnt_tc = 1'b1; cyc();
      total++; if (obs !== ex(5, 1'b0)) begin bad++; $display("FAIL tc_done got=%b exp=%b", obs, ex(5, 1'b0)); end
      game_over = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         total++; if (obs !== ex(5, 1'b0)) begin bad++; $display("FAIL tc_hold[%0d] got=%b exp=%b", i, obs, ex(5, 1'b0)); end
      end
      cnt_tc = 1'b0; game_over = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      total++; if (obs !== ex(1, 1'b0)) begin bad++; $display("FAIL tc_reload got=%b exp=%b", obs, ex(1, 1'b0)); end
      cyc();
      total++; if (obs !== ex(2, 1'b0)) begin bad++; $display("FAIL tc_rerun got=%b exp=%b", obs, ex(2, 1'b0)); end
   endtask

   task automatic test_game_over();
      pause = 1'b1; cyc(); pause = 1'b0;
      total++; if (obs !== ex(3, 1'b0)) begin bad++; $display("FAIL go_pause got=%b exp=%b", obs, ex(3, 1'b0)); end
      game_over = 1'b1; cyc(); game_over = 1'b0;
      total++; if (obs !== ex(5, 1'b0)) begin bad++; $display("FAIL go_paused got=%b exp=%b", obs, ex(5, 1'b0)); end
      start = 1'b1; cyc(); start = 1'b0; cyc();
      crash = 1'b1; cyc(); crash = 1'b0;
      total++; if (obs !== ex(4, 1'b0)) begin bad++; $display("FAIL go_crash got=%b exp=%b", obs, ex(4, 1'b0)); end
      game_over = 1'b1; cyc(); game_over = 1'b0;
      total++; if (obs !== ex(5, 1'b0)) begin bad++; $display("FAIL go_penalty got=%b exp=%b", obs, ex(5, 1'b0)); end
      start = 1'b1; cyc(); start = 1'b0; cyc();
      game_over = 1'b1; pause = 1'b1; cyc(); game_over = 1'b0; pause = 1'b0;
      total++; if (obs !== ex(5, 1'b0)) begin bad++; $display("FAIL go_pause_prio got=%b exp=%b", obs, ex(5, 1'b0)); end
   endtask

   // Crash landing on the same cycle as a penalty tick.
   task automatic test_crash_tick();
      start = 1'b1; cyc(); start = 1'b0; cyc();
      crash = 1'b1; cyc(); crash = 1'b0;
      total++; if (obs !== ex(4, 1'b0)) begin bad++; $display("FAIL ct_entry got=%b exp=%b", obs, ex(4, 1'b0)); end
      for (int c = 2; c <= 8; c++) begin
         cyc();
         total++; if (obs !== ex(4, (c % 4) == 0)) begin bad++; $display("FAIL ct[%0d] got=%b exp=%b", c, obs, ex(4, (c % 4) == 0)); end
      end
      crash = 1'b1; cyc(); crash = 1'b0;
      for (int c = 9; c <= 20; c++) begin
         if (c > 9) cyc();
         total++; if (obs !== ex(4, (c % 4) == 0)) begin bad++; $display("FAIL ct_reload[%0d] got=%b exp=%b", c, obs, ex(4, (c % 4) == 0)); end
      end
      cyc();
      total++; if (obs !== ex(2, 1'b0)) begin bad++; $display("FAIL ct_exit got=%b exp=%b", obs, ex(2, 1'b0)); end
   endtask

   task automatic test_reset_mid();
      crash = 1'b1; cyc(); crash = 1'b0;
      total++; if (obs !== ex(4, 1'b0)) begin bad++; $display("FAIL rm_pen got=%b exp=%b", obs, ex(4, 1'b0)); end
      cyc();
      reset = 1'b1; cyc(); reset = 1'b0;
      total++; if (obs !== ex(0, 1'b0)) begin bad++; $display("FAIL rm_reset got=%b exp=%b", obs, ex(0, 1'b0)); end
      crash = 1'b1; cyc(); crash = 1'b0;
      total++; if (obs !== ex(0, 1'b0)) begin bad++; $display("FAIL rm_crash got=%b exp=%b", obs, ex(0, 1'b0)); end
      pause = 1'b1; cyc(); pause = 1'b0;
      total++; if (obs !== ex(0, 1'b0)) begin bad++; $display("FAIL rm_pause got=%b exp=%b", obs, ex(0, 1'b0)); end
      for (int i = 0; i < 6; i++) begin
         cyc();
         total++; if (obs !== ex(0, 1'b0)) begin bad++; $display("FAIL rm_idle[%0d] got=%b exp=%b", i, obs, ex(0, 1'b0)); end
      end
      start = 1'b1; cyc(); start = 1'b0;
      total++; if (obs !== ex(1, 1'b0)) begin bad++; $display("FAIL rm_load got=%b exp=%b", obs, ex(1, 1'b0)); end
      cyc();
      total++; if (obs !== ex(2, 1'b0)) begin bad++; $display("FAIL rm_run got=%b exp=%b", obs, ex(2, 1'b0)); end
   endtask

   initial begin
      test_reset();
      test_start_run();
      test_pause();
      test_penalty();
      test_tc();
      test_game_over();
      test_crash_tick();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
